multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main sequencing FSM for the multi-cycle RV32I core.
- Walks each instruction through fetch, decode, execute, memory and writeback, and drives the datapath strobes.
- Drives alu_op into the existing ALU decoder with the core's encoding: 00 add, 01 branch compare, 10 R-type, 11 I-type.
- Handles the instruction/data memory req/ready handshake with a watchdog timeout, and traps on illegal opcodes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for mem_ready before faulting; range 1..65535.
- CNT_W, 16: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  branch condition result from the ALU/comparator for the current funct3.
- pc_write  out  1  load PC from the result mux.
- ir_write  out  1  latch fetched word into IR and current PC into old_pc.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable; qualified by mem_req.
- reg_write  out  1  register file write.
- alu_src_a  out  2  ALU A select: 00 PC, 01 old_pc, 10 rs1, 11 zero.
- alu_src_b  out  2  ALU B select: 00 rs2, 01 imm, 10 constant 4.
- result_src  out  2  result select: 00 ALUOut register, 01 memory read data, 10 ALU result direct.
- alu_op  out  2  to the ALU decoder, encoding as in Overview.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky.
- state_dbg  out  4  current state code.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous, active-high.
- Reset: state becomes FETCH, wait counter 0, fault 00. While rst is high all outputs are forced to 0, including state_dbg. The first active cycle after release is FETCH.
- Output style: Moore outputs decoded from state; mem_ready and branch_taken only qualify pc_write, ir_write and transitions. Any strobe not listed for a state is 0. alu_op is 00 unless stated.
- States and codes:
  - FETCH (0): mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10. On mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - DECODE (1): alu_src_a=01, alu_src_b=01, so ALUOut becomes old_pc+imm. Dispatch on opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0010111 → ALUWB (AUIPC)
    - 0110111 → LUI
    - anything else → TRAP with fault=01
  - MEMADR (2): alu_src_a=10, alu_src_b=01. Next is MEMRD if opcode[5]=0, else MEMWR.
  - MEMRD (3): mem_req=1, adr_src=1. On mem_ready → MEMWB.
  - MEMWB (4): result_src=01, reg_write=1, instr_done=1 → FETCH.
  - MEMWR (5): mem_req=1, mem_we=1, adr_src=1. On mem_ready: instr_done=1 → FETCH.
  - EXEC_R (6): alu_src_a=10, alu_src_b=00, alu_op=10 → ALUWB.
  - EXEC_I (7): alu_src_a=10, alu_src_b=01, alu_op=11 → ALUWB.
  - ALUWB (8): result_src=00, reg_write=1, instr_done=1 → FETCH.
  - BRANCH (9): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=branch_taken, instr_done=1 → FETCH.
  - JAL (10): alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1 → ALUWB, which writes old_pc+4.
  - JALR (11): alu_src_a=10, alu_src_b=01, result_src=10, pc_write=1 → LINK.
  - LINK (12): alu_src_a=01, alu_src_b=10 → ALUWB.
  - LUI (13): alu_src_a=11, alu_src_b=01 → ALUWB.
  - TRAP (15): all strobes 0; held until rst.
- Latency in cycles with mem_ready high on the first request cycle: branch 3, AUIPC 3, R/I/LUI 4, store 4, JAL 4, load 5, JALR 5. Each cycle of mem_ready low adds one.
- Handshake:
  - mem_req, mem_we and adr_src stay stable until the mem_ready cycle; mem_req drops the cycle after.
  - mem_ready is ignored in non-request states.
  - Every request state is at least one cycle; no back-to-back request is merged.
- Timeout:
  - The wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_ready is low in those states.
  - When the counter equals TIMEOUT_CYCLES with mem_ready still low: go to TRAP, fault=10, mem_req drops the next cycle.
  - mem_ready high in the same cycle as the timeout wins: normal completion.
- Reset mid-request: the request is abandoned; mem_req goes low in the same cycle rst is high; no write or PC update occurs.
- Fault priority: the first fault latched is kept; TRAP never overwrites it.

Test Plan:
- Reset, then R-type add (opcode 0110011) with mem_ready immediate → state_dbg sequence 0,1,6,8. alu_op=10 in EXEC_R. reg_write and instr_done high only in cycle 4.
- Load (0000011) with mem_ready delayed 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4. mem_req steady with adr_src=1 throughout. reg_write with result_src=01 in MEMWB. Total 8 cycles.
- BEQ (1100011): branch_taken=1 → pc_write=1, alu_op=01 in BRANCH. Repeat with branch_taken=0 → pc_write=0. Both complete in 3 cycles.
- JALR (1100111) → states 0,1,11,12,8. pc_write in JALR with result_src=10. reg_write in ALUWB with the LINK-computed old_pc+4.
- Opcode 1111111 → TRAP, fault=01, all strobes 0 for 20 cycles. rst → FETCH, fault=00.
- TIMEOUT_CYCLES=4, mem_ready held low in FETCH → TRAP on the 5th wait cycle, fault=10. Separately: rst asserted in the 2nd MEMWR wait cycle → mem_we/mem_req low the same cycle, state FETCH afterwards.

Source files
------------

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multi-cycle RV32I core: fetch/decode/execute/memory/writeback strobes.
// Latency: branch/AUIPC 3, R/I/LUI/store/JAL 4, load/JALR 5 cycles, plus one per cycle of mem_ready low.
// Backpressure: request states hold mem_req/mem_we/adr_src until mem_ready; a watchdog traps after TIMEOUT_CYCLES.
//
// Ports: clk/rst (sync, active-high); opcode, mem_ready, branch_taken in;
//        datapath strobes (pc_write, ir_write, adr_src, mem_req, mem_we, reg_write,
//        alu_src_a/b, result_src, alu_op), instr_done, sticky fault and state_dbg out.
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic [1:0] fault,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_LINK   = 4'd12,
        S_LUI    = 4'd13,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       fault_q;
    logic             req_state;
    logic             wait_expired;

    assign req_state    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // Ready in the same cycle as expiry still completes the access.
    assign wait_expired = (wait_cnt == TIMEOUT_VAL) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            fault_q  <= FAULT_NONE;
        end else begin
            // Counter only runs while a request is stalled; any other cycle
            // leaves it at zero, so every request state is entered with 0.
            if (req_state && !mem_ready && !wait_expired)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;

            if (req_state && wait_expired) begin
                state <= S_TRAP;
                if (fault_q == FAULT_NONE)
                    fault_q <= FAULT_TIMEOUT;
            end else begin
                case (state)
                    S_FETCH:  if (mem_ready) state <= S_DECODE;
                    S_DECODE: begin
                        case (opcode)
                            7'b0000011, 7'b0100011: state <= S_MEMADR;
                            7'b0110011:             state <= S_EXEC_R;
                            7'b0010011:             state <= S_EXEC_I;
                            7'b1100011:             state <= S_BRANCH;
                            7'b1101111:             state <= S_JAL;
                            7'b1100111:             state <= S_JALR;
                            7'b0010111:             state <= S_ALUWB;
                            7'b0110111:             state <= S_LUI;
                            default: begin
                                state <= S_TRAP;
                                if (fault_q == FAULT_NONE)
                                    fault_q <= FAULT_ILLEGAL;
                            end
                        endcase
                    end
                    // opcode[5] separates stores (0100011) from loads (0000011).
                    S_MEMADR: state <= opcode[5] ? S_MEMWR : S_MEMRD;
                    S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                    S_MEMWR:  if (mem_ready) state <= S_FETCH;
                    S_MEMWB, S_ALUWB, S_BRANCH: state <= S_FETCH;
                    S_EXEC_R, S_EXEC_I, S_JAL, S_LINK, S_LUI: state <= S_ALUWB;
                    S_JALR:   state <= S_LINK;
                    S_TRAP:   state <= S_TRAP;
                    default:  state <= S_FETCH;
                endcase
            end
        end
    end

    // Strobes decode from state; mem_ready/branch_taken only qualify pc/ir writes.
    // Everything is forced low while rst is high so an in-flight access is dropped at once.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        fault      = 2'b00;
        state_dbg  = 4'd0;
        if (!rst) begin
            fault     = fault_q;
            state_dbg = state;
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_req    = 1'b1;
                    mem_we     = 1'b1;
                    adr_src    = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b11;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 2'b10;
                    alu_op     = 2'b01;
                    pc_write   = branch_taken;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_JALR: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                end
                S_LINK: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed per-cycle vector table, hand sequences for
// watchdog corners, and randomized instructions scored against a latency/strobe-count model.
module tb_multicycle_control;

    localparam int TMO = 4;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_ILL  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       pc_write, ir_write, adr_src, mem_req, mem_we, reg_write, instr_done;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op, fault;
    logic [3:0] state_dbg;

    int vectors = 0;
    int miscompares = 0;

    multicycle_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
        .adr_src(adr_src), .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_op(alu_op), .instr_done(instr_done), .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [6:0] op;
        logic       rdy;
        logic       bt;
        logic [3:0] st;
        logic [5:0] strb;   // pc_write, ir_write, adr_src, mem_req, mem_we, reg_write
        logic [1:0] a, b, rs, aop;
        logic       done;
        logic [1:0] flt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [6:0] op, input logic rdy, input logic bt,
                       input logic [3:0] st, input logic [5:0] strb, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] rs, input logic [1:0] aop,
                       input logic done, input logic [1:0] flt);
        vec_t v;
        v.r = r; v.op = op; v.rdy = rdy; v.bt = bt; v.st = st; v.strb = strb;
        v.a = a; v.b = b; v.rs = rs; v.aop = aop; v.done = done; v.flt = flt;
        vecs.push_back(v);
    endtask

    task automatic add_fetch(input logic [6:0] op, input logic rdy, input logic bt);
        add(0, op, rdy, bt, 4'd0, rdy ? 6'b110100 : 6'b000100, 2'b00, 2'b10, 2'b10, 2'b00, 0, 2'b00);
    endtask

    task automatic add_decode(input logic [6:0] op, input logic bt);
        add(0, op, 0, bt, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b00);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int base_latency(input logic [6:0] op);
        case (op)
            OP_BR, OP_AUI:                return 3;
            OP_R, OP_I, OP_LUI, OP_ST, OP_JAL: return 4;
            default:                      return 5;   // load, JALR
        endcase
    endfunction

    task automatic run_random(input logic [6:0] op, input int df, input int dm, input logic bt);
        int cycles = 0, rw = 0, pw = 0, mrq = 0, mwe = 0, req_no = 0, waited = 0, lim;
        int exp_cycles, exp_rw, exp_pw, exp_mrq, exp_mwe;
        logic done_seen = 1'b0;
        logic [1:0] last_fault = 2'b00;
        bit ldst = (op == OP_LD) || (op == OP_ST);
        while (!done_seen && cycles < 60) begin
            @(negedge clk);
            if (cycles == 0) begin
                opcode = op;
                branch_taken = bt;
            end
            if (mem_req) begin
                lim = (req_no == 0) ? df : dm;
                mem_ready = (waited >= lim);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));   // must be ignored here
            end
            #1;
            cycles++;
            rw  += int'(reg_write);
            pw  += int'(pc_write);
            mrq += int'(mem_req);
            mwe += int'(mem_we);
            done_seen  = instr_done;
            last_fault = fault;
            if (mem_req) begin
                if (mem_ready) begin
                    req_no++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
        end
        exp_cycles = base_latency(op) + df + (ldst ? dm : 0);
        exp_rw  = (op == OP_ST || op == OP_BR) ? 0 : 1;
        exp_pw  = 1 + ((op == OP_JAL || op == OP_JALR) ? 1 : 0) + ((op == OP_BR && bt) ? 1 : 0);
        exp_mrq = df + 1 + (ldst ? dm + 1 : 0);
        exp_mwe = (op == OP_ST) ? dm + 1 : 0;
        check($sformatf("rand_latency op=%b df=%0d dm=%0d", op, df, dm), 32'(cycles), 32'(exp_cycles));
        check($sformatf("rand_strobes op=%b bt=%0b", op, bt),
              {6'd0, last_fault, rw[5:0], pw[5:0], mrq[5:0], mwe[5:0]},
              {6'd0, 2'b00, exp_rw[5:0], exp_pw[5:0], exp_mrq[5:0], exp_mwe[5:0]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [9];
        int n;

        // ---------------- vector table ----------------
        add(1, OP_R, 0, 0, 4'd0, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        add(1, OP_R, 1, 0, 4'd0, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        // R-type
        add_fetch(OP_R, 1, 0);
        add_decode(OP_R, 0);
        add(0, OP_R, 0, 0, 4'd6, 6'b000000, 2'b10, 2'b00, 2'b00, 2'b10, 0, 2'b00);
        add(0, OP_R, 0, 0, 4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00);
        // load, ready delayed 3 cycles in MEMRD
        add_fetch(OP_LD, 1, 0);
        add_decode(OP_LD, 0);
        add(0, OP_LD, 0, 0, 4'd2, 6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 2'b00);
        for (int i = 0; i < 3; i++)
            add(0, OP_LD, 0, 0, 4'd3, 6'b001100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        add(0, OP_LD, 1, 0, 4'd3, 6'b001100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        add(0, OP_LD, 0, 0, 4'd4, 6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 1, 2'b00);
        // BEQ taken / not taken
        add_fetch(OP_BR, 1, 1);
        add_decode(OP_BR, 1);
        add(0, OP_BR, 0, 1, 4'd9, 6'b100000, 2'b10, 2'b00, 2'b00, 2'b01, 1, 2'b00);
        add_fetch(OP_BR, 1, 0);
        add_decode(OP_BR, 0);
        add(0, OP_BR, 0, 0, 4'd9, 6'b000000, 2'b10, 2'b00, 2'b00, 2'b01, 1, 2'b00);
        // JALR
        add_fetch(OP_JALR, 1, 0);
        add_decode(OP_JALR, 0);
        add(0, OP_JALR, 0, 0, 4'd11, 6'b100000, 2'b10, 2'b01, 2'b10, 2'b00, 0, 2'b00);
        add(0, OP_JALR, 0, 0, 4'd12, 6'b000000, 2'b01, 2'b10, 2'b00, 2'b00, 0, 2'b00);
        add(0, OP_JALR, 0, 0, 4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00);
        // store, reset in the 2nd MEMWR wait cycle
        add_fetch(OP_ST, 1, 0);
        add_decode(OP_ST, 0);
        add(0, OP_ST, 0, 0, 4'd2, 6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 2'b00);
        add(0, OP_ST, 0, 0, 4'd5, 6'b001110, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        add(1, OP_ST, 1, 0, 4'd0, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        add_fetch(OP_ILL, 0, 0);
        // illegal opcode, TRAP held 20 cycles with inputs toggling
        add_fetch(OP_ILL, 1, 0);
        add_decode(OP_ILL, 0);
        for (int i = 0; i < 20; i++)
            add(0, OP_ILL, i[0], ~i[0], 4'd15, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b01);
        add(1, OP_ILL, 0, 0, 4'd0, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        add_fetch(OP_R, 0, 0);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].r;
            opcode = vecs[k].op;
            mem_ready = vecs[k].rdy;
            branch_taken = vecs[k].bt;
            #1;
            check($sformatf("vec%0d", k),
                  {11'd0, state_dbg, pc_write, ir_write, adr_src, mem_req, mem_we, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_op, instr_done, fault},
                  {11'd0, vecs[k].st, vecs[k].strb, vecs[k].a, vecs[k].b, vecs[k].rs,
                   vecs[k].aop, vecs[k].done, vecs[k].flt});
        end

        // ---------------- watchdog: ready never comes in FETCH ----------------
        @(negedge clk); rst = 1; mem_ready = 0;
        @(negedge clk); rst = 0;
        n = 0;
        #1;
        while (state_dbg != 4'd15 && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("timeout_fetch_cycles", 32'(n), 32'(TMO + 1));
        check("timeout_fault_req", {29'd0, fault, mem_req}, {29'd0, 2'b10, 1'b0});
        repeat (3) @(negedge clk);
        #1;
        check("timeout_fault_sticky", {28'd0, state_dbg}, {28'd0, 4'd15});

        // ---------------- ready arriving exactly at the timeout count wins ----------------
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; mem_ready = 0; opcode = OP_R;
        repeat (TMO) @(negedge clk);
        mem_ready = 1;
        #1;
        check("ready_wins_pcw", {30'd0, pc_write, ir_write}, {30'd0, 2'b11});
        @(negedge clk); mem_ready = 0;
        #1;
        check("ready_wins_state", {26'd0, fault, state_dbg}, {26'd0, 2'b00, 4'd1});
        repeat (2) @(negedge clk);   // EXEC_R, ALUWB finish the instruction

        // ---------------- randomized instructions ----------------
        ops = '{OP_LD, OP_ST, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_AUI, OP_LUI};
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        for (int t = 0; t < 150; t++) begin
            run_random(ops[$urandom_range(0, 8)], int'($urandom_range(0, TMO)),
                       int'($urandom_range(0, TMO)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
